// File: rtl/snake_line_renderer_if.sv
// Bundle between the game-state logic / VGA timing generator (master side)
// and the snake line renderer (slave side).
//   Master drives : pixel_xpos/ypos, line_req, line_y, food_x/y, cur_len,
//                   seg_x/seg_y (flattened, segment 0 = head in the LSBs)
//   Slave drives  : pixel_data (RGB565), scan_busy, scan_ovf, hit_w, hit_self
interface snake_line_renderer_if #(
  parameter int COORD_W = 10,
  parameter int LEN_W   = 6,
  parameter int MAX_LEN = 32
);
  logic [COORD_W-1:0]         pixel_xpos;
  logic [COORD_W-1:0]         pixel_ypos;
  logic                       line_req;
  logic [COORD_W-1:0]         line_y;
  logic [COORD_W-1:0]         food_x;
  logic [COORD_W-1:0]         food_y;
  logic [LEN_W-1:0]           cur_len;
  logic [MAX_LEN*COORD_W-1:0] seg_x;
  logic [MAX_LEN*COORD_W-1:0] seg_y;
  logic [15:0]                pixel_data;
  logic                       scan_busy;
  logic                       scan_ovf;
  logic                       hit_w;
  logic                       hit_self;

  modport master (
    output pixel_xpos, pixel_ypos, line_req, line_y, food_x, food_y,
           cur_len, seg_x, seg_y,
    input  pixel_data, scan_busy, scan_ovf, hit_w, hit_self
  );

  modport slave (
    input  pixel_xpos, pixel_ypos, line_req, line_y, food_x, food_y,
           cur_len, seg_x, seg_y,
    output pixel_data, scan_busy, scan_ovf, hit_w, hit_self
  );
endinterface

// File: rtl/snake_line_renderer.sv
// Snake-game pixel renderer. Each upcoming scan line is rasterised into a
// ping-pong line buffer (bank = line[0]) one segment per cycle, so snake
// length scales without a wide comparator tree. A 2-stage pixel pipeline
// then colours the current scan position from border/food/buffer flags.
// Also produces registered wall-hit and frame-delayed self-hit flags.
// Ports:
//   vga_clk   : pixel clock
//   sys_rst_n : asynchronous active-low reset
//   bus       : snake_line_renderer_if.slave (scan position, line request,
//               game state in; pixel_data and status flags out)
module snake_line_renderer #(
  parameter int H_DISP     = 640,
  parameter int V_DISP     = 480,
  parameter int SIDE_W     = 10,
  parameter int BLOCK_LOG2 = 4,
  parameter int MAX_LEN    = 32,
  parameter int COORD_W    = 10,
  parameter int LEN_W      = 6
) (
  input  logic                 vga_clk,
  input  logic                 sys_rst_n,
  snake_line_renderer_if.slave bus
);

  localparam int BLOCK_W = 1 << BLOCK_LOG2;
  localparam int COLS    = H_DISP >> BLOCK_LOG2;
  localparam int COL_W   = $clog2(COLS);
  localparam int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int XC_W    = COORD_W - BLOCK_LOG2;

  // Constants one bit wider than a coordinate so coord+BLOCK_W never wraps.
  localparam logic [COORD_W:0] C_BLK    = (COORD_W+1)'(BLOCK_W);
  localparam logic [COORD_W:0] C_SIDE   = (COORD_W+1)'(SIDE_W);
  localparam logic [COORD_W:0] C_HDISP  = (COORD_W+1)'(H_DISP);
  localparam logic [COORD_W:0] C_RIGHT  = (COORD_W+1)'(H_DISP - SIDE_W);
  localparam logic [COORD_W:0] C_BOTTOM = (COORD_W+1)'(V_DISP - SIDE_W);
  localparam logic [COORD_W:0] C_HX_MAX = (COORD_W+1)'(H_DISP - SIDE_W - BLOCK_W);
  localparam logic [COORD_W:0] C_HY_MAX = (COORD_W+1)'(V_DISP - SIDE_W - BLOCK_W);
  localparam logic [XC_W:0]    C_COLS   = (XC_W+1)'(COLS);
  localparam logic [LEN_W-1:0] C_MAXLEN = LEN_W'(MAX_LEN);

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  // Colour priority: border > food > head > odd body > even body > background
  function automatic logic [15:0] f_colour(input logic       border,
                                           input logic       food,
                                           input logic [1:0] code);
    if (border)         return 16'h8A22;
    else if (food)      return 16'hFFFF;
    else if (code == 2'd1) return 16'hF800;
    else if (code == 2'd2) return 16'hFD20;
    else if (code == 2'd3) return 16'h7FFA;
    else                return 16'h0000;
  endfunction

  state_t               r_state;
  state_t               w_state_nxt;
  logic [COORD_W-1:0]   r_line_l;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_ovf;
  logic                 r_self_acc;
  logic                 r_hit_self;
  logic                 r_hit_w;
  logic [1:0]           r_buf [2][COLS];

  logic                 r_border_p1;
  logic                 r_food_p1;
  logic [1:0]           r_code_p1;
  logic [15:0]          r_pixel_p2;

  logic                 w_start;
  logic                 w_seg_act;
  logic                 w_busy;
  logic [LEN_W-1:0]     w_len_cl;
  logic [IDX_W-1:0]     w_idx_init;
  logic [COORD_W-1:0]   w_sx;
  logic [COORD_W-1:0]   w_sy;
  logic [COORD_W-1:0]   w_hx;
  logic [COORD_W-1:0]   w_hy;
  logic [XC_W-1:0]      w_wcol;
  logic                 w_col_ok;
  logic                 w_y_hit;
  logic [1:0]           w_wcode;
  logic                 w_self_set;
  logic                 w_frame;
  logic                 w_hit_w;
  logic [COORD_W-1:0]   w_px;
  logic [COORD_W-1:0]   w_py;
  logic [XC_W-1:0]      w_rcol;
  logic [1:0]           w_rcode;
  logic                 w_border;
  logic                 w_food;

  // ---------------- segment under scan and head ----------------
  assign w_sx = bus.seg_x[r_idx*COORD_W +: COORD_W];
  assign w_sy = bus.seg_y[r_idx*COORD_W +: COORD_W];
  assign w_hx = bus.seg_x[COORD_W-1:0];
  assign w_hy = bus.seg_y[COORD_W-1:0];

  assign w_len_cl   = (bus.cur_len > C_MAXLEN) ? C_MAXLEN : bus.cur_len;
  assign w_idx_init = IDX_W'(w_len_cl - LEN_W'(1));

  assign w_wcol   = w_sx[COORD_W-1:BLOCK_LOG2];
  assign w_col_ok = {1'b0, w_wcol} < C_COLS;
  assign w_y_hit  = (w_sy <= r_line_l) &&
                    ({1'b0, r_line_l} < ({1'b0, w_sy} + C_BLK));
  assign w_wcode  = (r_idx == '0) ? 2'd1 : (r_idx[0] ? 2'd2 : 2'd3);

  assign w_self_set = (r_state == S_SCAN) && (r_idx != '0) &&
                      (w_sx == w_hx) && (w_sy == w_hy);
  assign w_frame    = bus.line_req && (bus.line_y == '0);

  assign w_hit_w = ({1'b0, w_hx} < C_SIDE) || ({1'b0, w_hx} > C_HX_MAX) ||
                   ({1'b0, w_hy} < C_SIDE) || ({1'b0, w_hy} > C_HY_MAX);

  // ---------------- rasteriser FSM ----------------
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.line_req && (w_len_cl != '0)) w_state_nxt = S_SCAN;
      S_SCAN: begin
        // A new request aborts and restarts exactly like a request from IDLE.
        if (bus.line_req)        w_state_nxt = (w_len_cl != '0) ? S_SCAN : S_IDLE;
        else if (r_idx == '0)    w_state_nxt = S_IDLE;
        else                     w_state_nxt = S_SCAN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_start   = bus.line_req;
    w_busy    = (r_state == S_SCAN);
    w_seg_act = (r_state == S_SCAN) && !bus.line_req;
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_line_l   <= '0;
      r_idx      <= '0;
      r_ovf      <= 1'b0;
      r_self_acc <= 1'b0;
      r_hit_self <= 1'b0;
      r_hit_w    <= 1'b0;
    end else begin
      r_hit_w <= w_hit_w;
      if (w_start) begin
        r_line_l <= bus.line_y;
        r_idx    <= w_idx_init;
      end else if (w_seg_act) begin
        r_idx <= r_idx - IDX_W'(1);
      end
      if (w_start && (r_state == S_SCAN)) r_ovf <= 1'b1;
      // Frame boundary publishes the accumulated flag; a same-cycle set wins.
      if (w_frame) r_hit_self <= r_self_acc;
      if (w_self_set)   r_self_acc <= 1'b1;
      else if (w_frame) r_self_acc <= 1'b0;
    end
  end

  // Line buffers. Descending scan means lower indices overwrite higher ones,
  // which gives the head priority without extra logic.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < COLS; c++)
          r_buf[b][c] <= 2'd0;
    end else if (w_start) begin
      for (int c = 0; c < COLS; c++)
        r_buf[bus.line_y[0]][c] <= 2'd0;
    end else if (w_seg_act && w_y_hit && w_col_ok) begin
      r_buf[r_line_l[0]][w_wcol[COL_W-1:0]] <= w_wcode;
    end
  end

  // ---------------- pixel pipeline ----------------
  assign w_px     = bus.pixel_xpos;
  assign w_py     = bus.pixel_ypos;
  assign w_rcol   = w_px[COORD_W-1:BLOCK_LOG2];
  assign w_rcode  = ({1'b0, w_px} < C_HDISP) ? r_buf[w_py[0]][w_rcol[COL_W-1:0]] : 2'd0;
  assign w_border = ({1'b0, w_px} < C_SIDE) || ({1'b0, w_px} >= C_RIGHT) ||
                    ({1'b0, w_py} < C_SIDE) || ({1'b0, w_py} >= C_BOTTOM);
  assign w_food   = (bus.food_x <= w_px) &&
                    ({1'b0, w_px} < ({1'b0, bus.food_x} + C_BLK)) &&
                    (bus.food_y <= w_py) &&
                    ({1'b0, w_py} < ({1'b0, bus.food_y} + C_BLK));

  // Stage p1: region flags and buffer code
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_border_p1 <= 1'b0;
      r_food_p1   <= 1'b0;
      r_code_p1   <= 2'd0;
    end else begin
      r_border_p1 <= w_border;
      r_food_p1   <= w_food;
      r_code_p1   <= w_rcode;
    end
  end

  // Stage p2: colour resolve
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_pixel_p2 <= 16'h0000;
    else            r_pixel_p2 <= f_colour(r_border_p1, r_food_p1, r_code_p1);
  end

  assign bus.pixel_data = r_pixel_p2;
  assign bus.scan_busy  = w_busy;
  assign bus.scan_ovf   = r_ovf;
  assign bus.hit_w      = r_hit_w;
  assign bus.hit_self   = r_hit_self;

endmodule
